sr_write_ctrl: RTL and testbench
================================

// Module: sr_write_ctrl
// PURPOSE
//  Schedules every write to the MSP430 status register (R2/SR). Arbitrates ALU flag updates,
//  explicit SR-destination writes, interrupt entry and RETI restore; drives the SR mux select
//  (MSR) and the mux data input. Sits between the instruction decoder/ALU and the SR mux.
//  Runs the multi-cycle interrupt-entry and RETI sequences and stalls the decoder meanwhile.
// PARAMETERS
//  SR_W        16       SR width
//  FLAG_MASK   16'h0107 SR bits an ALU update may change (V,N,Z,C)
//  IRQ_KEEP    16'h0040 SR bits kept on interrupt entry (SCG0); all others cleared
// PORTS
//  clk          in   1     system clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  reg_SR_out   in   SR_W  current SR from register file
//  func_req     in   1     ALU requests flag update this cycle
//  func_flags   in   SR_W  ALU flag vector (only FLAG_MASK bits used)
//  reg_wr_req   in   1     instruction writes SR as destination
//  reg_wr_data  in   SR_W  full SR value for explicit write
//  irq_req      in   1     interrupt accepted; start entry sequence
//  reti_req     in   1     RETI decoded; start restore sequence
//  save_ack     in   1     stack unit accepted sr_save_data
//  pop_valid    in   1     stack unit presents popped SR
//  pop_data     in   SR_W  popped SR value
//  MSR          out  1     SR mux select: 1 = take sr_ctrl_out, 0 = hold reg_SR_out
//  sr_ctrl_out  out  SR_W  data to SR mux func input
//  sr_save_vld  out  1     SR push request to stack unit
//  sr_save_data out  SR_W  SR value to push
//  func_gnt     out  1     ALU update applied
//  reg_gnt      out  1     explicit write applied
//  irq_done     out  1     one-cycle pulse: entry sequence finished
//  reti_done    out  1     one-cycle pulse: restore finished
//  busy         out  1     stall decoder; high whenever state != IDLE
// BEHAVIOUR
//  - All outputs registered; rst forces state=IDLE and every output to 0 (async).
//  - Latency: request sampled at edge N -> MSR/sr_ctrl_out/gnt valid cycle N+1, one cycle.
//  - MSR = 1 exactly in cycles where the SR is written; otherwise 0.
//  - FSM states: IDLE, IRQ_SAVE, IRQ_CLR, RETI_WAIT.
//  - IDLE priority: irq_req > reti_req > reg_wr_req > func_req. Losers get no grant, no
//    queuing; requester must hold request (decoder sees busy / missing gnt).
//  - func update: sr_ctrl_out = (reg_SR_out & ~FLAG_MASK) | (func_flags & FLAG_MASK).
//  - reg write: sr_ctrl_out = reg_wr_data (full word). reg_wr_req and func_req together:
//    reg write wins, func_gnt=0 (destination SR overrides flags, MSP430 semantics).
//  - irq_req in IDLE -> IRQ_SAVE: sr_save_vld=1, sr_save_data=SR captured at entry; hold
//    until save_ack sampled high -> IRQ_CLR: one cycle MSR=1, sr_ctrl_out=captured & IRQ_KEEP,
//    irq_done=1 -> IDLE. No SR write during IRQ_SAVE.
//  - reti_req in IDLE -> RETI_WAIT: wait pop_valid; on pop_valid: MSR=1,
//    sr_ctrl_out=pop_data, reti_done=1 -> IDLE. pop_valid already high on entry cycle is
//    ignored; only sampled in RETI_WAIT.
//  - All requests ignored while busy; irq_req during RETI_WAIT is not latched.
//  - save_ack/pop_valid in IDLE ignored. No timeout: stall indefinitely until handshake.
//  - rst mid-sequence: abort, no SR write, no done pulse, sr_save_vld drops immediately.
// STRUCTURE
//  - Shared header msp430_sr_defs.vh: SR bit indices (C=0,Z=1,N=2,GIE=3,CPUOFF=4,
//    OSCOFF=5,SCG0=6,SCG1=7,V=8), default FLAG_MASK/IRQ_KEEP, FSM state encodings.
//  - Single module, no sub-modules; output drives existing mux_sr (MSR, func_SR_out input).
// TESTING
//  1 reset: assert rst mid-IRQ_SAVE -> all outputs 0 same cycle, state IDLE after release.
//  2 func_req, func_flags=16'hFFFF, reg_SR_out=16'h0008 -> next cycle MSR=1,
//    sr_ctrl_out=16'h010F, func_gnt=1.
//  3 func_req+reg_wr_req same cycle, reg_wr_data=16'h0123 -> sr_ctrl_out=16'h0123,
//    reg_gnt=1, func_gnt=0.
//  4 irq_req, reg_SR_out=16'h00F9, save_ack after 3 cycles -> sr_save_data=16'h00F9 held 3
//    cycles, then MSR=1 sr_ctrl_out=16'h0040 irq_done=1; busy high throughout.
//  5 reti_req, pop_valid after 2 cycles with pop_data=16'h0108 -> MSR=1,
//    sr_ctrl_out=16'h0108, reti_done=1; func_req during wait never granted.
//  6 irq_req+reti_req same cycle -> IRQ sequence runs; reti ignored until re-asserted in IDLE.

Source files
------------

// File: rtl/sr_write_ctrl_pkg.sv
// Shared definitions for the MSP430 status-register write scheduler:
// SR bit positions, default masks and sequencer state encodings.
package sr_write_ctrl_pkg;

   localparam int SR_W_DEF = 16;

   localparam int SR_BIT_C      = 0;
   localparam int SR_BIT_Z      = 1;
   localparam int SR_BIT_N      = 2;
   localparam int SR_BIT_GIE    = 3;
   localparam int SR_BIT_CPUOFF = 4;
   localparam int SR_BIT_OSCOFF = 5;
   localparam int SR_BIT_SCG0   = 6;
   localparam int SR_BIT_SCG1   = 7;
   localparam int SR_BIT_V      = 8;

   // ALU may only touch V,N,Z,C; interrupt entry keeps only SCG0
   localparam logic [15:0] FLAG_MASK_DEF = 16'h0107;
   localparam logic [15:0] IRQ_KEEP_DEF  = 16'h0040;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_IRQ_SAVE  = 2'd1;
   localparam logic [1:0] ST_IRQ_CLR   = 2'd2;
   localparam logic [1:0] ST_RETI_WAIT = 2'd3;

endpackage

// File: rtl/sr_write_ctrl.sv
// Arbitrates every write to R2/SR (ALU flags, explicit writes, interrupt entry,
// RETI restore) and drives the SR mux; all outputs come straight from flops.
module sr_write_ctrl
   import sr_write_ctrl_pkg::*;
#(
   parameter int              SR_W      = SR_W_DEF,
   parameter logic [SR_W-1:0] FLAG_MASK = FLAG_MASK_DEF,
   parameter logic [SR_W-1:0] IRQ_KEEP  = IRQ_KEEP_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SR_W-1:0] reg_SR_out,
   input  logic            func_req,
   input  logic [SR_W-1:0] func_flags,
   input  logic            reg_wr_req,
   input  logic [SR_W-1:0] reg_wr_data,
   input  logic            irq_req,
   input  logic            reti_req,
   input  logic            save_ack,
   input  logic            pop_valid,
   input  logic [SR_W-1:0] pop_data,
   output logic            MSR,
   output logic [SR_W-1:0] sr_ctrl_out,
   output logic            sr_save_vld,
   output logic [SR_W-1:0] sr_save_data,
   output logic            func_gnt,
   output logic            reg_gnt,
   output logic            irq_done,
   output logic            reti_done,
   output logic            busy
);

   logic [1:0]      state_q,        state_d;
   logic [SR_W-1:0] cap_q,          cap_d;
   logic            msr_q,          msr_d;
   logic [SR_W-1:0] sr_ctrl_out_q,  sr_ctrl_out_d;
   logic            sr_save_vld_q,  sr_save_vld_d;
   logic [SR_W-1:0] sr_save_data_q, sr_save_data_d;
   logic            func_gnt_q,     func_gnt_d;
   logic            reg_gnt_q,      reg_gnt_d;
   logic            irq_done_q,     irq_done_d;
   logic            reti_done_q,    reti_done_d;
   logic            busy_q,         busy_d;

   // Next-state and next-output computation for the SR write sequencer
   always_comb begin
      state_d        = state_q;
      cap_d          = cap_q;
      msr_d          = 1'b0;
      sr_ctrl_out_d  = {SR_W{1'b0}};
      sr_save_vld_d  = 1'b0;
      sr_save_data_d = {SR_W{1'b0}};
      func_gnt_d     = 1'b0;
      reg_gnt_d      = 1'b0;
      irq_done_d     = 1'b0;
      reti_done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (irq_req) begin
               state_d        = ST_IRQ_SAVE;
               cap_d          = reg_SR_out;
               sr_save_vld_d  = 1'b1;
               sr_save_data_d = reg_SR_out;
            end else if (reti_req) begin
               state_d = ST_RETI_WAIT;
            end else if (reg_wr_req) begin
               // destination-SR write overrides the flag update of the same instruction
               msr_d         = 1'b1;
               sr_ctrl_out_d = reg_wr_data;
               reg_gnt_d     = 1'b1;
            end else if (func_req) begin
               msr_d         = 1'b1;
               sr_ctrl_out_d = (reg_SR_out & ~FLAG_MASK) | (func_flags & FLAG_MASK);
               func_gnt_d    = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IRQ_SAVE: begin
            if (save_ack) begin
               state_d       = ST_IRQ_CLR;
               msr_d         = 1'b1;
               sr_ctrl_out_d = cap_q & IRQ_KEEP;
               irq_done_d    = 1'b1;
            end else begin
               sr_save_vld_d  = 1'b1;
               sr_save_data_d = cap_q;
            end
         end
         ST_IRQ_CLR: begin
            state_d = ST_IDLE;
         end
         ST_RETI_WAIT: begin
            // pop_valid is only looked at here, never on the entry cycle
            if (pop_valid) begin
               state_d       = ST_IDLE;
               msr_d         = 1'b1;
               sr_ctrl_out_d = pop_data;
               reti_done_d   = 1'b1;
            end else begin
               state_d = ST_RETI_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset aborts any sequence without writing SR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cap_q          <= {SR_W{1'b0}};
         msr_q          <= 1'b0;
         sr_ctrl_out_q  <= {SR_W{1'b0}};
         sr_save_vld_q  <= 1'b0;
         sr_save_data_q <= {SR_W{1'b0}};
         func_gnt_q     <= 1'b0;
         reg_gnt_q      <= 1'b0;
         irq_done_q     <= 1'b0;
         reti_done_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cap_q          <= cap_d;
         msr_q          <= msr_d;
         sr_ctrl_out_q  <= sr_ctrl_out_d;
         sr_save_vld_q  <= sr_save_vld_d;
         sr_save_data_q <= sr_save_data_d;
         func_gnt_q     <= func_gnt_d;
         reg_gnt_q      <= reg_gnt_d;
         irq_done_q     <= irq_done_d;
         reti_done_q    <= reti_done_d;
         busy_q         <= busy_d;
      end
   end

   assign MSR          = msr_q;
   assign sr_ctrl_out  = sr_ctrl_out_q;
   assign sr_save_vld  = sr_save_vld_q;
   assign sr_save_data = sr_save_data_q;
   assign func_gnt     = func_gnt_q;
   assign reg_gnt      = reg_gnt_q;
   assign irq_done     = irq_done_q;
   assign reti_done    = reti_done_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sr_write_ctrl.sv
// Self-checking bench for sr_write_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_sr_write_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] reg_SR_out = 16'h0000;
   logic        func_req = 1'b0;
   logic [15:0] func_flags = 16'h0000;
   logic        reg_wr_req = 1'b0;
   logic [15:0] reg_wr_data = 16'h0000;
   logic        irq_req = 1'b0;
   logic        reti_req = 1'b0;
   logic        save_ack = 1'b0;
   logic        pop_valid = 1'b0;
   logic [15:0] pop_data = 16'h0000;
   logic        MSR;
   logic [15:0] sr_ctrl_out;
   logic        sr_save_vld;
   logic [15:0] sr_save_data;
   logic        func_gnt, reg_gnt, irq_done, reti_done, busy;

   int checks = 0;
   int errors = 0;

   sr_write_ctrl dut (
      .clk(clk), .rst(rst), .reg_SR_out(reg_SR_out),
      .func_req(func_req), .func_flags(func_flags),
      .reg_wr_req(reg_wr_req), .reg_wr_data(reg_wr_data),
      .irq_req(irq_req), .reti_req(reti_req),
      .save_ack(save_ack), .pop_valid(pop_valid), .pop_data(pop_data),
      .MSR(MSR), .sr_ctrl_out(sr_ctrl_out),
      .sr_save_vld(sr_save_vld), .sr_save_data(sr_save_data),
      .func_gnt(func_gnt), .reg_gnt(reg_gnt),
      .irq_done(irq_done), .reti_done(reti_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] sr;
      logic        freq;
      logic [15:0] flags;
      logic        wreq;
      logic [15:0] wdata;
      logic        ack;
      logic        pop;
      logic        e_msr;
      logic [15:0] e_ctrl;
      logic        e_fgnt;
      logic        e_rgnt;
      logic        e_busy;
   } vec_t;

   vec_t vecs[7];

   // reference model: what the SR unit is doing, as plain flags
   bit          m_saving, m_clearing, m_restoring;
   logic [15:0] m_saved;
   logic        x_msr, x_vld, x_fgnt, x_rgnt, x_idone, x_rdone, x_busy;
   logic [15:0] x_ctrl, x_sdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".MSR"}, {31'd0, MSR}, 32'd0);
      chk({tag, ".vld"}, {31'd0, sr_save_vld}, 32'd0);
      chk({tag, ".fgnt"}, {31'd0, func_gnt}, 32'd0);
      chk({tag, ".rgnt"}, {31'd0, reg_gnt}, 32'd0);
      chk({tag, ".idone"}, {31'd0, irq_done}, 32'd0);
      chk({tag, ".rdone"}, {31'd0, reti_done}, 32'd0);
   endtask

   // Predict outputs for the coming clock edge from the current inputs
   task automatic model_edge();
      x_msr = 1'b0; x_vld = 1'b0; x_fgnt = 1'b0; x_rgnt = 1'b0;
      x_idone = 1'b0; x_rdone = 1'b0; x_ctrl = 16'h0000; x_sdata = 16'h0000;
      if (rst) begin
         m_saving = 1'b0; m_clearing = 1'b0; m_restoring = 1'b0;
      end else if (m_clearing) begin
         m_clearing = 1'b0;
      end else if (m_saving) begin
         if (save_ack) begin
            m_saving = 1'b0; m_clearing = 1'b1;
            x_msr = 1'b1; x_ctrl = m_saved & 16'h0040; x_idone = 1'b1;
         end else begin
            x_vld = 1'b1; x_sdata = m_saved;
         end
      end else if (m_restoring) begin
         if (pop_valid) begin
            m_restoring = 1'b0;
            x_msr = 1'b1; x_ctrl = pop_data; x_rdone = 1'b1;
         end
      end else if (irq_req) begin
         m_saving = 1'b1; m_saved = reg_SR_out;
         x_vld = 1'b1; x_sdata = reg_SR_out;
      end else if (reti_req) begin
         m_restoring = 1'b1;
      end else if (reg_wr_req) begin
         x_msr = 1'b1; x_ctrl = reg_wr_data; x_rgnt = 1'b1;
      end else if (func_req) begin
         x_msr = 1'b1; x_fgnt = 1'b1;
         for (int b = 0; b < 16; b++)
            x_ctrl[b] = (b == 0 || b == 1 || b == 2 || b == 8) ? func_flags[b] : reg_SR_out[b];
      end
      x_busy = m_saving | m_clearing | m_restoring;
   endtask

   task automatic idle_inputs();
      func_req = 1'b0; reg_wr_req = 1'b0; irq_req = 1'b0; reti_req = 1'b0;
      save_ack = 1'b0; pop_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{16'h0008, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h010F, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{16'h0008, 1'b1, 16'hFFFF, 1'b1, 16'h0123, 1'b0, 1'b0, 1'b1, 16'h0123, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{16'hFFFF, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFEF8, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{16'h00F0, 1'b1, 16'h5AA5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00F5, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{16'h0007, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0};

      // reset state
      tick(); tick();
      chk_quiet("reset");
      chk("reset.busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick();

      // single-cycle IDLE arbitration vectors
      for (int i = 0; i < 7; i++) begin
         reg_SR_out = vecs[i].sr; func_req = vecs[i].freq; func_flags = vecs[i].flags;
         reg_wr_req = vecs[i].wreq; reg_wr_data = vecs[i].wdata;
         save_ack = vecs[i].ack; pop_valid = vecs[i].pop;
         tick();
         chk($sformatf("vec%0d.MSR", i), {31'd0, MSR}, {31'd0, vecs[i].e_msr});
         chk($sformatf("vec%0d.fgnt", i), {31'd0, func_gnt}, {31'd0, vecs[i].e_fgnt});
         chk($sformatf("vec%0d.rgnt", i), {31'd0, reg_gnt}, {31'd0, vecs[i].e_rgnt});
         chk($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
         if (vecs[i].e_msr)
            chk($sformatf("vec%0d.ctrl", i), {16'd0, sr_ctrl_out}, {16'd0, vecs[i].e_ctrl});
      end
      idle_inputs();
      tick();

      // interrupt entry with save_ack after three cycles
      reg_SR_out = 16'h00F9; irq_req = 1'b1;
      tick();
      irq_req = 1'b0; reg_SR_out = 16'h1234;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("irq.vld%0d", c), {31'd0, sr_save_vld}, 32'd1);
         chk($sformatf("irq.sdata%0d", c), {16'd0, sr_save_data}, 32'h00F9);
         chk($sformatf("irq.msr%0d", c), {31'd0, MSR}, 32'd0);
         chk($sformatf("irq.busy%0d", c), {31'd0, busy}, 32'd1);
         if (c == 2) save_ack = 1'b1;
         tick();
      end
      save_ack = 1'b0;
      chk("irq.clr.MSR", {31'd0, MSR}, 32'd1);
      chk("irq.clr.ctrl", {16'd0, sr_ctrl_out}, 32'h0040);
      chk("irq.clr.done", {31'd0, irq_done}, 32'd1);
      chk("irq.clr.vld", {31'd0, sr_save_vld}, 32'd0);
      chk("irq.clr.busy", {31'd0, busy}, 32'd1);
      tick();
      chk_quiet("irq.after");
      chk("irq.after.busy", {31'd0, busy}, 32'd0);

      // RETI: pop_valid on entry cycle ignored, func_req starved while waiting
      reti_req = 1'b1; pop_valid = 1'b1; pop_data = 16'hDEAD;
      tick();
      reti_req = 1'b0; pop_valid = 1'b0; func_req = 1'b1; func_flags = 16'hFFFF;
      chk("reti.w1.busy", {31'd0, busy}, 32'd1);
      chk("reti.w1.MSR", {31'd0, MSR}, 32'd0);
      tick();
      chk("reti.w2.busy", {31'd0, busy}, 32'd1);
      chk("reti.w2.fgnt", {31'd0, func_gnt}, 32'd0);
      chk("reti.w2.MSR", {31'd0, MSR}, 32'd0);
      pop_valid = 1'b1; pop_data = 16'h0108;
      tick();
      idle_inputs();
      chk("reti.MSR", {31'd0, MSR}, 32'd1);
      chk("reti.ctrl", {16'd0, sr_ctrl_out}, 32'h0108);
      chk("reti.done", {31'd0, reti_done}, 32'd1);
      chk("reti.fgnt", {31'd0, func_gnt}, 32'd0);
      tick();
      chk_quiet("reti.after");

      // irq and reti together: irq wins, reti not remembered
      reg_SR_out = 16'h0048; irq_req = 1'b1; reti_req = 1'b1;
      tick();
      irq_req = 1'b0; reti_req = 1'b0;
      chk("both.vld", {31'd0, sr_save_vld}, 32'd1);
      chk("both.sdata", {16'd0, sr_save_data}, 32'h0048);
      save_ack = 1'b1;
      tick();
      save_ack = 1'b0;
      chk("both.idone", {31'd0, irq_done}, 32'd1);
      chk("both.ctrl", {16'd0, sr_ctrl_out}, 32'h0040);
      tick();
      chk("both.after.busy", {31'd0, busy}, 32'd0);
      chk("both.after.rdone", {31'd0, reti_done}, 32'd0);
      reti_req = 1'b1;
      tick();
      reti_req = 1'b0;
      chk("both.reti.busy", {31'd0, busy}, 32'd1);
      pop_valid = 1'b1; pop_data = 16'h0005;
      tick();
      pop_valid = 1'b0;
      chk("both.reti.done", {31'd0, reti_done}, 32'd1);
      chk("both.reti.ctrl", {16'd0, sr_ctrl_out}, 32'h0005);
      tick();

      // reset asserted mid save phase
      reg_SR_out = 16'h00FF; irq_req = 1'b1;
      tick();
      irq_req = 1'b0;
      chk("rst.pre.vld", {31'd0, sr_save_vld}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_quiet("rst.mid");
      chk("rst.mid.busy", {31'd0, busy}, 32'd0);
      chk("rst.mid.sdata", {16'd0, sr_save_data}, 32'd0);
      save_ack = 1'b1;
      tick();
      rst = 1'b0; save_ack = 1'b0;
      chk_quiet("rst.held");
      func_req = 1'b1; func_flags = 16'h0001; reg_SR_out = 16'h0000;
      tick();
      func_req = 1'b0;
      chk("rst.idle.fgnt", {31'd0, func_gnt}, 32'd1);
      chk("rst.idle.ctrl", {16'd0, sr_ctrl_out}, 32'h0001);
      chk("rst.idle.idone", {31'd0, irq_done}, 32'd0);
      tick();

      // randomized run against the reference model
      m_saving = 1'b0; m_clearing = 1'b0; m_restoring = 1'b0; m_saved = 16'h0000;
      for (int n = 0; n < 3000; n++) begin
         rst         = ($urandom_range(0, 299) == 0);
         irq_req     = ($urandom_range(0, 9) == 0);
         reti_req    = ($urandom_range(0, 9) == 0);
         reg_wr_req  = ($urandom_range(0, 3) == 0);
         func_req    = ($urandom_range(0, 1) == 0);
         save_ack    = ($urandom_range(0, 2) == 0);
         pop_valid   = ($urandom_range(0, 2) == 0);
         reg_SR_out  = 16'($urandom);
         func_flags  = 16'($urandom);
         reg_wr_data = 16'($urandom);
         pop_data    = 16'($urandom);
         model_edge();
         tick();
         chk("rnd.MSR", {31'd0, MSR}, {31'd0, x_msr});
         chk("rnd.vld", {31'd0, sr_save_vld}, {31'd0, x_vld});
         chk("rnd.fgnt", {31'd0, func_gnt}, {31'd0, x_fgnt});
         chk("rnd.rgnt", {31'd0, reg_gnt}, {31'd0, x_rgnt});
         chk("rnd.idone", {31'd0, irq_done}, {31'd0, x_idone});
         chk("rnd.rdone", {31'd0, reti_done}, {31'd0, x_rdone});
         chk("rnd.busy", {31'd0, busy}, {31'd0, x_busy});
         if (x_msr) chk("rnd.ctrl", {16'd0, sr_ctrl_out}, {16'd0, x_ctrl});
         if (x_vld) chk("rnd.sdata", {16'd0, sr_save_data}, {16'd0, x_sdata});
      end
      rst = 1'b0;
      idle_inputs();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
